// File: rtl/stack_controller_pkg.sv
// Shared definitions for the stack-machine control unit.
// Holds the 4-bit state encoding, the 3-bit opcode and 2-bit ALUOp constants,
// the bundle of datapath control strobes, and the opcode-to-ALUOp mapping.
package stack_controller_pkg;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_POPA  = 4'd2,
    S_POPB  = 4'd3,
    S_EXE   = 4'd4,
    S_WBALU = 4'd5,
    S_MEMRD = 4'd6,
    S_WBMEM = 4'd7,
    S_POPST = 4'd8,
    S_MEMWR = 4'd9,
    S_JMP   = 4'd10,
    S_TOSRD = 4'd11,
    S_JZ    = 4'd12
  } state_e;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       pcSrc;
    logic       IorD;
    logic       memRead;
    logic       memWrite;
    logic       IRWrite;
    logic       MtoS;
    logic       ldA;
    logic       ldB;
    logic       srcA;
    logic       srcB;
    logic       push;
    logic       pop;
    logic       tos;
    logic [1:0] ALUOp;
  } ctrl_t;

  // ALU operation for an arithmetic/logic opcode. Only meaningful in EXE,
  // where the opcode is always one of the four ALU instructions.
  function automatic logic [1:0] alu_op_of(input logic [2:0] op);
    logic [1:0] res;
    case (op)
      OP_ADD:  res = ALU_ADD;
      OP_SUB:  res = ALU_SUB;
      OP_AND:  res = ALU_AND;
      default: res = ALU_NOT;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/stack_ctrl_decode.sv
// Combinational Moore decoder: maps the current controller state to the full
// set of datapath control strobes. Anything not asserted for a state is 0.
// Ports:
//   state_i   current FSM state
//   opcode_i  IR[7:5], used only in EXE to select the ALU operation
//   ctrl_o    decoded control strobes
module stack_ctrl_decode
  import stack_controller_pkg::*;
(
  input  state_e      state_i,
  input  logic [2:0]  opcode_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    ctrl_o.ALUOp = ALU_ADD;
    case (state_i)
      S_IF: begin
        // Fetch and PC <= PC + 1 in the same cycle.
        ctrl_o.memRead = 1'b1;
        ctrl_o.IRWrite = 1'b1;
        ctrl_o.srcA    = 1'b1;
        ctrl_o.srcB    = 1'b1;
        ctrl_o.pcWrite = 1'b1;
      end
      S_POPA, S_POPST: begin
        ctrl_o.pop = 1'b1;
        ctrl_o.ldA = 1'b1;
      end
      S_POPB: begin
        ctrl_o.pop = 1'b1;
        ctrl_o.ldB = 1'b1;
      end
      S_EXE: begin
        ctrl_o.ALUOp = alu_op_of(opcode_i);
      end
      S_WBALU: begin
        ctrl_o.push = 1'b1;
      end
      S_MEMRD: begin
        ctrl_o.IorD    = 1'b1;
        ctrl_o.memRead = 1'b1;
      end
      S_WBMEM: begin
        ctrl_o.MtoS = 1'b1;
        ctrl_o.push = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.IorD     = 1'b1;
        ctrl_o.memWrite = 1'b1;
      end
      S_JMP: begin
        ctrl_o.pcSrc   = 1'b1;
        ctrl_o.pcWrite = 1'b1;
      end
      S_TOSRD: begin
        ctrl_o.tos = 1'b1;
      end
      S_JZ: begin
        ctrl_o.pcSrc       = 1'b1;
        ctrl_o.pcWriteCond = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stack_controller.sv
// Multicycle control FSM for the 8-opcode stack machine. Sequences fetch,
// decode and per-instruction execute/writeback, one microstep per clock,
// and drives every datapath control strobe (Moore, from state only).
// Optional feature: define INSTR_CNT_EN to add a 16-bit retired-instruction
// counter on output instr_count.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   opcode            IR[7:5] from the datapath
//   pcWrite .. tos    1-bit datapath control strobes
//   ALUOp             2-bit ALU operation select
//   instr_count       (INSTR_CNT_EN only) retired instruction count
module stack_controller
  import stack_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  opcode,
  output logic        pcWrite,
  output logic        pcWriteCond,
  output logic        pcSrc,
  output logic        IorD,
  output logic        memRead,
  output logic        memWrite,
  output logic        IRWrite,
  output logic        MtoS,
  output logic        ldA,
  output logic        ldB,
  output logic        srcA,
  output logic        srcB,
  output logic        push,
  output logic        pop,
  output logic        tos,
  output logic [1:0]  ALUOp
`ifdef INSTR_CNT_EN
  ,
  output logic [15:0] instr_count
`endif
);

  state_e state_q, state_d;
  // Remembers in ID whether this is the single-operand NOT, so POPA can
  // branch without looking at the opcode again.
  logic   unary_q, unary_d;
  ctrl_t  dec_ctrl, ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      unary_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unary_q <= unary_d;
    end
  end

  always_comb begin
    state_d = S_IF;
    unary_d = unary_q;
    case (state_q)
      S_IF:    state_d = S_ID;
      S_ID: begin
        unary_d = (opcode == OP_NOT);
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_NOT: state_d = S_POPA;
          OP_PUSH: state_d = S_MEMRD;
          OP_POP:  state_d = S_POPST;
          OP_JMP:  state_d = S_JMP;
          default: state_d = S_TOSRD;
        endcase
      end
      S_POPA:  state_d = unary_q ? S_EXE : S_POPB;
      S_POPB:  state_d = S_EXE;
      S_EXE:   state_d = S_WBALU;
      S_WBALU: state_d = S_IF;
      S_MEMRD: state_d = S_WBMEM;
      S_WBMEM: state_d = S_IF;
      S_POPST: state_d = S_MEMWR;
      S_MEMWR: state_d = S_IF;
      S_JMP:   state_d = S_IF;
      S_TOSRD: state_d = S_JZ;
      S_JZ:    state_d = S_IF;
      // Unused encodings recover to fetch.
      default: state_d = S_IF;
    endcase
  end

  stack_ctrl_decode u_decode (
    .state_i  (state_q),
    .opcode_i (opcode),
    .ctrl_o   (dec_ctrl)
  );

  // Strobes are forced low for the whole time reset is held, even though
  // the state register only returns to IF at the next edge.
  assign ctrl = rst ? '0 : dec_ctrl;

  assign pcWrite     = ctrl.pcWrite;
  assign pcWriteCond = ctrl.pcWriteCond;
  assign pcSrc       = ctrl.pcSrc;
  assign IorD        = ctrl.IorD;
  assign memRead     = ctrl.memRead;
  assign memWrite    = ctrl.memWrite;
  assign IRWrite     = ctrl.IRWrite;
  assign MtoS        = ctrl.MtoS;
  assign ldA         = ctrl.ldA;
  assign ldB         = ctrl.ldB;
  assign srcA        = ctrl.srcA;
  assign srcB        = ctrl.srcB;
  assign push        = ctrl.push;
  assign pop         = ctrl.pop;
  assign tos         = ctrl.tos;
  assign ALUOp       = ctrl.ALUOp;

`ifdef INSTR_CNT_EN
  logic [15:0] instr_cnt_q, instr_cnt_d;

  // An instruction retires on every entry into IF from another state;
  // the 16-bit add wraps naturally.
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    if (state_q != S_IF && state_d == S_IF) begin
      instr_cnt_d = instr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_q <= 16'd0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign instr_count = instr_cnt_q;
`endif

endmodule

// File: tb/tb_stack_controller.sv
// Self-checking bench for stack_controller: a table of per-opcode latency and
// key microstep expectations, hand-written reset sequences, and randomized
// instruction streams checked against a microstep-list reference model.
module tb_stack_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  opcode;
  logic        pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite;
  logic        MtoS, ldA, ldB, srcA, srcB, push, pop, tos;
  logic [1:0]  ALUOp;
`ifdef INSTR_CNT_EN
  logic [15:0] instr_count;
  int          exp_cnt = 0;
`endif

  stack_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSrc(pcSrc), .IorD(IorD),
    .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite), .MtoS(MtoS),
    .ldA(ldA), .ldB(ldB), .srcA(srcA), .srcB(srcB),
    .push(push), .pop(pop), .tos(tos), .ALUOp(ALUOp)
`ifdef INSTR_CNT_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bit positions in the packed observation word.
  localparam int B_PCW = 16, B_PCWC = 15, B_PCSRC = 14, B_IORD = 13;
  localparam int B_MRD = 12, B_MWR = 11, B_IRW = 10, B_MTOS = 9;
  localparam int B_LDA = 8, B_LDB = 7, B_SRCA = 6, B_SRCB = 5;
  localparam int B_PUSH = 4, B_POP = 3, B_TOS = 2;

  localparam logic [16:0] ONE = 17'd1;
  localparam logic [16:0] W_IF    = (ONE << B_PCW) | (ONE << B_MRD) | (ONE << B_IRW)
                                  | (ONE << B_SRCA) | (ONE << B_SRCB);
  localparam logic [16:0] W_ID    = 17'd0;
  localparam logic [16:0] W_POPA  = (ONE << B_POP) | (ONE << B_LDA);
  localparam logic [16:0] W_POPB  = (ONE << B_POP) | (ONE << B_LDB);
  localparam logic [16:0] W_WBALU = (ONE << B_PUSH);
  localparam logic [16:0] W_MEMRD = (ONE << B_IORD) | (ONE << B_MRD);
  localparam logic [16:0] W_WBMEM = (ONE << B_MTOS) | (ONE << B_PUSH);
  localparam logic [16:0] W_POPST = (ONE << B_POP) | (ONE << B_LDA);
  localparam logic [16:0] W_MEMWR = (ONE << B_IORD) | (ONE << B_MWR);
  localparam logic [16:0] W_JMP   = (ONE << B_PCSRC) | (ONE << B_PCW);
  localparam logic [16:0] W_TOSRD = (ONE << B_TOS);
  localparam logic [16:0] W_JZ    = (ONE << B_PCSRC) | (ONE << B_PCWC);

  function automatic logic [16:0] ctrl_word();
    return {pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS,
            ldA, ldB, srcA, srcB, push, pop, tos, ALUOp};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: the list of microsteps (as observation words) that an
  // instruction goes through, starting with its fetch.
  typedef logic [16:0] seq_t[$];

  function automatic seq_t model_seq(input logic [2:0] op);
    seq_t s;
    s.push_back(W_IF);
    s.push_back(W_ID);
    if (op < 3'd4) begin
      s.push_back(W_POPA);
      if (op != 3'd3) s.push_back(W_POPB);
      s.push_back({15'd0, op[1:0]});
      s.push_back(W_WBALU);
    end else if (op == 3'd4) begin
      s.push_back(W_MEMRD);
      s.push_back(W_WBMEM);
    end else if (op == 3'd5) begin
      s.push_back(W_POPST);
      s.push_back(W_MEMWR);
    end else if (op == 3'd6) begin
      s.push_back(W_JMP);
    end else begin
      s.push_back(W_TOSRD);
      s.push_back(W_JZ);
    end
    return s;
  endfunction

  // Entered at a negedge during IF; leaves at the negedge of the next IF.
  task automatic run_model_instr(input logic [2:0] op);
    seq_t s;
    s = model_seq(op);
    foreach (s[k]) begin
      check($sformatf("op%0d_step%0d", op, k), {15'd0, ctrl_word()}, {15'd0, s[k]});
      if (k == 0) opcode = op;
      @(negedge clk);
    end
`ifdef INSTR_CNT_EN
    exp_cnt = (exp_cnt + 1) % 65536;
    check("instr_count", {16'd0, instr_count}, exp_cnt);
`endif
    // Junk during fetch: the opcode must not matter until ID.
    opcode = 3'($urandom);
  endtask

  typedef struct {
    logic [2:0]  op;
    int          lat;
    logic [16:0] pen_word;   // second-to-last microstep
    logic [16:0] last_word;  // last microstep before returning to IF
  } vec_t;

  task automatic run_vec(input vec_t v);
    logic [16:0] w [0:31];
    int k;
    check($sformatf("vec%0d_IF", v.op), {15'd0, ctrl_word()}, {15'd0, W_IF});
    w[0] = ctrl_word();
    opcode = v.op;
    k = 1;
    @(negedge clk);
    while (k < 20 && !IRWrite) begin
      w[k] = ctrl_word();
      k++;
      @(negedge clk);
    end
    check($sformatf("vec%0d_latency", v.op), k, v.lat);
    if (k == v.lat) begin
      check($sformatf("vec%0d_pen", v.op), {15'd0, w[v.lat-2]}, {15'd0, v.pen_word});
      check($sformatf("vec%0d_last", v.op), {15'd0, w[v.lat-1]}, {15'd0, v.last_word});
    end
`ifdef INSTR_CNT_EN
    exp_cnt = (exp_cnt + 1) % 65536;
`endif
    opcode = 3'($urandom);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_IF", {15'd0, ctrl_word()}, {15'd0, W_IF});
`ifdef INSTR_CNT_EN
    exp_cnt = 0;
    check("count_after_reset", {16'd0, instr_count}, 32'd0);
`endif
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{3'd0, 6, 17'h00000, W_WBALU};
    vecs[1] = '{3'd1, 6, 17'h00001, W_WBALU};
    vecs[2] = '{3'd2, 6, 17'h00002, W_WBALU};
    vecs[3] = '{3'd3, 5, 17'h00003, W_WBALU};
    vecs[4] = '{3'd4, 4, W_MEMRD,   W_WBMEM};
    vecs[5] = '{3'd5, 4, W_POPST,   W_MEMWR};
    vecs[6] = '{3'd6, 3, W_ID,      W_JMP};
    vecs[7] = '{3'd7, 4, W_TOSRD,   W_JZ};

    rst = 1'b1;
    opcode = 3'd0;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs_zero", {15'd0, ctrl_word()}, 32'd0);
    end
    release_reset();

    foreach (vecs[i]) run_vec(vecs[i]);

    for (int n = 0; n < 150; n++) run_model_instr(3'($urandom_range(0, 7)));

    // Reset asserted in the middle of an ADD (during EXE), held 3 cycles.
    opcode = 3'd0;
    repeat (4) @(negedge clk);       // IF, ID, POPA, POPB -> now in EXE
    check("midexe_is_exe", {15'd0, ctrl_word()}, 32'd0);
    rst = 1'b1;
    #1 check("midexe_reset_zero", {15'd0, ctrl_word()}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("midexe_hold_zero", {15'd0, ctrl_word()}, 32'd0);
    end
    release_reset();

    // Reset during POPST, where strobes are nonzero before reset.
    opcode = 3'd5;
    repeat (2) @(negedge clk);
    check("popst_before_reset", {15'd0, ctrl_word()}, {15'd0, W_POPST});
    rst = 1'b1;
    #1 check("popst_reset_zero", {15'd0, ctrl_word()}, 32'd0);
    repeat (2) @(negedge clk);
    release_reset();

    run_model_instr(3'd0);
    run_model_instr(3'd4);
    run_model_instr(3'd6);
`ifdef INSTR_CNT_EN
    check("count_add_push_jmp", {16'd0, instr_count}, 32'd3);
`endif

    for (int n = 0; n < 40; n++) run_model_instr(3'($urandom_range(0, 7)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
